// File: rtl/uart_baud_pkg.sv
// Shared widths and FSM encoding for the UART baud-rate reconfiguration controller.
package uart_baud_pkg;

  localparam int BAUD_W      = 13;
  localparam int FRAC_W      = 3;
  localparam int DRAIN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SYNC  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_drain_qual.sv
// Drain qualifier: flags two consecutive idle cycles of TX/RX while enabled, plus an
// optional DRAIN timeout counter built only when UART_BAUD_CFG_TIMEOUT_EN is defined.
module uart_drain_qual
  import uart_baud_pkg::*;
#(
  parameter logic [DRAIN_CNT_W-1:0] DRAIN_TIMEOUT = 16'd4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic drain_en,
  input  logic tx_busy,
  input  logic rx_busy,
  output logic drain_ok,
  output logic drain_timeout
);

  logic w_idle;
  logic r_idle_seen;

  assign w_idle = !tx_busy && !rx_busy;

  // Remembers that the previous DRAIN cycle was idle; any busy cycle restarts qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_seen <= 1'b0;
    end else if (!drain_en) begin
      r_idle_seen <= 1'b0;
    end else begin
      r_idle_seen <= w_idle;
    end
  end

  assign drain_ok = drain_en && w_idle && r_idle_seen;

`ifdef UART_BAUD_CFG_TIMEOUT_EN
  localparam logic [DRAIN_CNT_W-1:0] TO_LAST = DRAIN_TIMEOUT - 16'd1;

  logic [DRAIN_CNT_W-1:0] r_to_cnt;

  // Counter holds zero outside DRAIN, so it starts from zero on every DRAIN entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (!drain_en) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign drain_timeout = drain_en && (r_to_cnt == TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^DRAIN_TIMEOUT;
  assign drain_timeout    = 1'b0;
`endif

endmodule

// File: rtl/uart_baud_cfg_ctrl.sv
// Baud reconfiguration controller: pauses TX/RX, drains, loads the new divisor and
// re-syncs to the baud tick. Optional DRAIN abort enabled by UART_BAUD_CFG_TIMEOUT_EN.
module uart_baud_cfg_ctrl
  import uart_baud_pkg::*;
#(
  parameter logic [BAUD_W-1:0]      RESET_BAUD_VAL = 13'd0,
  parameter logic [FRAC_W-1:0]      RESET_FRAC     = 3'd0,
  parameter logic [DRAIN_CNT_W-1:0] DRAIN_TIMEOUT  = 16'd4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [BAUD_W-1:0] cfg_baud_val,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              tx_busy,
  input  logic              rx_busy,
  input  logic              baud_clock,
  output logic              pause,
  output logic              gen_clear,
  output logic [BAUD_W-1:0] baud_val,
  output logic [FRAC_W-1:0] baud_val_fraction,
  output logic              cfg_done,
  output logic              cfg_err,
  output state_e            o_dbg_state
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_ready_en;
  logic [BAUD_W-1:0] r_shadow_baud;
  logic [FRAC_W-1:0] r_shadow_frac;
  logic [BAUD_W-1:0] r_baud;
  logic [FRAC_W-1:0] r_frac;
  logic              r_done;
  logic              w_accept;
  logic              w_in_drain;
  logic              w_drain_ok;
  logic              w_drain_timeout;

  // Handshake: a config transfers on a rising edge where cfg_valid && cfg_ready; cfg_ready
  // is high only in IDLE, and cfg_valid offered elsewhere is dropped, not queued.
  assign cfg_ready  = r_ready_en && (r_state == ST_IDLE);
  assign w_accept   = cfg_valid && cfg_ready;
  assign w_in_drain = (r_state == ST_DRAIN);

  uart_drain_qual #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain_qual (
    .clk          (clk),
    .reset_n      (reset_n),
    .drain_en     (w_in_drain),
    .tx_busy      (tx_busy),
    .rx_busy      (rx_busy),
    .drain_ok     (w_drain_ok),
    .drain_timeout(w_drain_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_DRAIN;
      ST_DRAIN: begin
        if (w_drain_ok) begin
          w_next_state = ST_LOAD;
        end else if (w_drain_timeout) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD:  w_next_state = ST_SYNC;
      ST_SYNC:  if (baud_clock) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // r_ready_en keeps cfg_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_en    <= 1'b0;
      r_shadow_baud <= '0;
      r_shadow_frac <= '0;
      r_baud        <= RESET_BAUD_VAL;
      r_frac        <= RESET_FRAC;
      r_done        <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_shadow_baud <= cfg_baud_val;
        r_shadow_frac <= cfg_frac;
      end
      if (r_state == ST_LOAD) begin
        r_baud <= r_shadow_baud;
        r_frac <= r_shadow_frac;
      end
      r_done <= (r_state == ST_SYNC) && baud_clock;
    end
  end

  assign pause             = (r_state != ST_IDLE);
  assign gen_clear         = (r_state == ST_LOAD);
  assign baud_val          = r_baud;
  assign baud_val_fraction = r_frac;
  assign cfg_done          = r_done;
  // Abort pulses in the last DRAIN cycle; a simultaneous drain_ok wins and suppresses it.
  assign cfg_err           = w_in_drain && w_drain_timeout && !w_drain_ok;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Directed bench for uart_baud_cfg_ctrl; covers the timeout path when
// UART_BAUD_CFG_TIMEOUT_EN is defined, otherwise the indefinite-drain path.
module tb_uart_baud_cfg_ctrl;
  import uart_baud_pkg::*;

  localparam logic [12:0] RST_BAUD = 13'd100;
  localparam logic [2:0]  RST_FRAC = 3'd2;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [12:0] cfg_baud_val;
  logic [2:0]  cfg_frac;
  logic        tx_busy;
  logic        rx_busy;
  logic        baud_clock;
  logic        pause;
  logic        gen_clear;
  logic [12:0] baud_val;
  logic [2:0]  baud_val_fraction;
  logic        cfg_done;
  logic        cfg_err;
  state_e      dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] exp_baud;
  logic [2:0]  exp_frac;
  logic [15:0] exp_q[$];

  uart_baud_cfg_ctrl #(
    .RESET_BAUD_VAL(RST_BAUD),
    .RESET_FRAC    (RST_FRAC),
    .DRAIN_TIMEOUT (16'd16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_baud_val     (cfg_baud_val),
    .cfg_frac         (cfg_frac),
    .tx_busy          (tx_busy),
    .rx_busy          (rx_busy),
    .baud_clock       (baud_clock),
    .pause            (pause),
    .gen_clear        (gen_clear),
    .baud_val         (baud_val),
    .baud_val_fraction(baud_val_fraction),
    .cfg_done         (cfg_done),
    .cfg_err          (cfg_err),
    .o_dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic load_expected();
    logic [15:0] v;
    if (exp_q.size() > 0) begin
      v        = exp_q.pop_front();
      exp_frac = v[15:13];
      exp_baud = v[12:0];
    end
  endtask

  task automatic offer(input logic [12:0] b, input logic [2:0] f);
    cfg_valid    = 1'b1;
    cfg_baud_val = b;
    cfg_frac     = f;
  endtask

  // Called at a negedge where the DUT is expected to be in LOAD.
  task automatic finish_cfg(input string nm, input int sync_wait);
    check({nm, "_load_state"}, dbg_state, ST_LOAD);
    check({nm, "_load_clear"}, gen_clear, 1'b1);
    check({nm, "_load_baud_old"}, baud_val, exp_baud);
    @(negedge clk);
    load_expected();
    check({nm, "_sync_state"}, dbg_state, ST_SYNC);
    check({nm, "_sync_baud"}, baud_val, exp_baud);
    check({nm, "_sync_frac"}, baud_val_fraction, exp_frac);
    check({nm, "_sync_clear"}, gen_clear, 1'b0);
    repeat (sync_wait) @(negedge clk);
    check({nm, "_sync_hold"}, dbg_state, ST_SYNC);
    check({nm, "_sync_nodone"}, cfg_done, 1'b0);
    baud_clock = 1'b1;
    @(negedge clk);
    baud_clock = 1'b0;
    check({nm, "_done"}, cfg_done, 1'b1);
    check({nm, "_done_pause"}, pause, 1'b0);
    check({nm, "_done_state"}, dbg_state, ST_IDLE);
    check({nm, "_done_ready"}, cfg_ready, 1'b1);
    check({nm, "_done_err"}, cfg_err, 1'b0);
    @(negedge clk);
    check({nm, "_done_pulse"}, cfg_done, 1'b0);
  endtask

  task automatic do_cfg(input string nm, input logic [12:0] b, input logic [2:0] f,
                        input int sync_wait);
    offer(b, f);
    exp_q.push_back({f, b});
    @(negedge clk);
    cfg_valid = 1'b0;
    check({nm, "_drain1_state"}, dbg_state, ST_DRAIN);
    check({nm, "_drain1_pause"}, pause, 1'b1);
    check({nm, "_drain1_ready"}, cfg_ready, 1'b0);
    check({nm, "_drain1_baud"}, baud_val, exp_baud);
    @(negedge clk);
    check({nm, "_drain2_state"}, dbg_state, ST_DRAIN);
    @(negedge clk);
    finish_cfg(nm, sync_wait);
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_valid    = 1'b0;
    cfg_baud_val = '0;
    cfg_frac     = '0;
    tx_busy      = 1'b0;
    rx_busy      = 1'b0;
    baud_clock   = 1'b0;
    exp_baud     = RST_BAUD;
    exp_frac     = RST_FRAC;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_pause", pause, 1'b0);
    check("rst_clear", gen_clear, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_baud", baud_val, RST_BAUD);
    check("rst_frac", baud_val_fraction, RST_FRAC);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", cfg_ready, 1'b1);
    check("rel_state", dbg_state, ST_IDLE);

    // Basic configuration, then an identical one that must still run fully
    do_cfg("basic", 13'd325, 3'd4, 2);
    do_cfg("same", 13'd325, 3'd4, 0);

    // tx_busy held across a long drain
    tx_busy = 1'b1;
    offer(13'd777, 3'd5);
    exp_q.push_back({3'd5, 13'd777});
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("txbusy_state", dbg_state, ST_DRAIN);
      check("txbusy_baud", baud_val, exp_baud);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    check("txfall_drain", dbg_state, ST_DRAIN);
    check("txfall_baud", baud_val, exp_baud);
    @(negedge clk);
    finish_cfg("txbusy", 1);

    // rx_busy held: abort with the timeout build, indefinite wait otherwise
    rx_busy = 1'b1;
    offer(13'd999, 3'd3);
`ifdef UART_BAUD_CFG_TIMEOUT_EN
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      check("to_wait_err", cfg_err, 1'b0);
      check("to_wait_state", dbg_state, ST_DRAIN);
      @(negedge clk);
    end
    check("to_err", cfg_err, 1'b1);
    check("to_err_done", cfg_done, 1'b0);
    check("to_err_state", dbg_state, ST_DRAIN);
    @(negedge clk);
    rx_busy = 1'b0;
    check("to_after_err", cfg_err, 1'b0);
    check("to_after_state", dbg_state, ST_IDLE);
    check("to_after_pause", pause, 1'b0);
    check("to_after_ready", cfg_ready, 1'b1);
    check("to_after_baud", baud_val, exp_baud);
    check("to_after_frac", baud_val_fraction, exp_frac);
`else
    exp_q.push_back({3'd3, 13'd999});
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("noto_err", cfg_err, 1'b0);
      check("noto_state", dbg_state, ST_DRAIN);
      @(negedge clk);
    end
    rx_busy = 1'b0;
    @(negedge clk);
    check("glitch_a", dbg_state, ST_DRAIN);
    rx_busy = 1'b1;
    @(negedge clk);
    check("glitch_b", dbg_state, ST_DRAIN);
    rx_busy = 1'b0;
    @(negedge clk);
    check("glitch_c", dbg_state, ST_DRAIN);
    @(negedge clk);
    finish_cfg("glitch", 0);
`endif

    // Second offer during SYNC is ignored, then taken in the cfg_done cycle
    offer(13'd1000, 3'd7);
    exp_q.push_back({3'd7, 13'd1000});
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    load_expected();
    check("insync_state", dbg_state, ST_SYNC);
    check("insync_baud", baud_val, 13'd1000);
    offer(13'd50, 3'd1);
    @(negedge clk);
    check("insync_ignored", dbg_state, ST_SYNC);
    check("insync_ready", cfg_ready, 1'b0);
    baud_clock = 1'b1;
    @(negedge clk);
    baud_clock = 1'b0;
    check("insync_done", cfg_done, 1'b1);
    check("insync_done_ready", cfg_ready, 1'b1);
    exp_q.push_back({3'd1, 13'd50});
    @(negedge clk);
    cfg_valid = 1'b0;
    check("second_accept", dbg_state, ST_DRAIN);
    check("second_baud_old", baud_val, 13'd1000);
    @(negedge clk);
    @(negedge clk);
    finish_cfg("second", 0);

    // Zero divisor is legal
    do_cfg("zero", 13'd0, 3'd0, 0);

    // Reset during DRAIN abandons the configuration silently
    tx_busy = 1'b1;
    offer(13'd1234, 3'd6);
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_pre", dbg_state, ST_DRAIN);
    #2 reset_n = 1'b0;
    #1;
    exp_baud = RST_BAUD;
    exp_frac = RST_FRAC;
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_pause", pause, 1'b0);
    check("mid_rst_ready", cfg_ready, 1'b0);
    check("mid_rst_baud", baud_val, exp_baud);
    check("mid_rst_frac", baud_val_fraction, exp_frac);
    check("mid_rst_done", cfg_done, 1'b0);
    @(negedge clk);
    tx_busy = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_done", cfg_done, 1'b0);
      check("post_rst_err", cfg_err, 1'b0);
      check("post_rst_state", dbg_state, ST_IDLE);
    end
    check("post_rst_baud", baud_val, RST_BAUD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_cfg_ctrl.md
UART_BAUD_CFG_CTRL -- requirements
Module: uart_baud_cfg_ctrl

Interface
REQ-001 Parameter: RESET_BAUD_VAL, 13'd0, baud divisor driven after reset.
REQ-002 Parameter: RESET_FRAC, 3'd0, fractional baud value driven after reset.
REQ-003 Parameter: DRAIN_TIMEOUT, 16'd4096, number of DRAIN-state cycles allowed before abort (used only when the timeout macro is defined).
REQ-004 Port: clk, in, 1, system clock; all logic is clocked on its rising edge.
REQ-005 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-006 Port: cfg_valid, in, 1, a new baud configuration is offered.
REQ-007 Port: cfg_ready, out, 1, controller can accept a configuration.
REQ-008 Port: cfg_baud_val, in, 13, requested divisor.
REQ-009 Port: cfg_frac, in, 3, requested fractional value.
REQ-010 Port: tx_busy, in, 1, transmitter is mid-frame.
REQ-011 Port: rx_busy, in, 1, receiver is mid-frame.
REQ-012 Port: baud_clock, in, 1, 16x pulse from the baud generator.
REQ-013 Port: pause, out, 1, TX and RX shall not start a new frame while this is high.
REQ-014 Port: gen_clear, out, 1, synchronous clear to the baud generator counters.
REQ-015 Port: baud_val, out, 13, registered divisor to the generator.
REQ-016 Port: baud_val_fraction, out, 3, registered fractional value to the generator.
REQ-017 Port: cfg_done, out, 1, one-cycle pulse when the new rate is live.
REQ-018 Port: cfg_err, out, 1, one-cycle pulse when a configuration is aborted.

Function
REQ-019 The FSM SHALL have four states: IDLE, DRAIN, LOAD and SYNC.
REQ-020 cfg_ready SHALL be high exactly when the state is IDLE.
- A handshake occurs when cfg_valid and cfg_ready are both high.
- cfg_valid in any other state is ignored and is not queued.
REQ-021 On a handshake the controller SHALL:
- capture cfg_baud_val and cfg_frac into shadow registers;
- enter DRAIN;
- raise pause on the next cycle.
REQ-022 DRAIN SHALL exit to LOAD only after tx_busy and rx_busy have both been low for 2 consecutive cycles.
- Any busy assertion restarts the 2-cycle qualification.
REQ-023 LOAD SHALL last exactly one cycle, with gen_clear=1.
- baud_val and baud_val_fraction take the shadow values at the end of LOAD.
REQ-024 SYNC SHALL wait for baud_clock=1.
- On the following cycle: cfg_done=1 for one cycle, pause=0, state returns to IDLE.
REQ-025 pause SHALL be high in DRAIN, LOAD and SYNC, and low in IDLE.
REQ-026 Boundary values SHALL be handled as follows:
- cfg_baud_val=0 is legal.
- A configuration equal to the current values still executes the full sequence.
REQ-027 baud_val and baud_val_fraction SHALL change only at the end of LOAD or on reset.
REQ-028 cfg_done and cfg_err SHALL never be high in the same cycle.

Reset
REQ-029 While reset_n is low, outputs SHALL be:
- state=IDLE;
- pause=0, gen_clear=0, cfg_done=0, cfg_err=0;
- baud_val=RESET_BAUD_VAL, baud_val_fraction=RESET_FRAC;
- shadow registers and the drain counter cleared.
REQ-030 cfg_ready SHALL be 0 while reset_n is low and 1 on the first cycle after release.
REQ-031 Reset asserted mid-sequence SHALL abandon the pending configuration with no cfg_done and no cfg_err pulse.

Configuration
REQ-032 With UART_BAUD_CFG_TIMEOUT_EN defined, the controller SHALL abort when DRAIN has lasted DRAIN_TIMEOUT cycles:
- a 16-bit counter is cleared on entry to DRAIN;
- on expiry: cfg_err pulses for one cycle, pause drops, state returns to IDLE;
- baud_val and baud_val_fraction are unchanged.
REQ-033 Without UART_BAUD_CFG_TIMEOUT_EN, DRAIN SHALL wait indefinitely; cfg_err is tied 0 and no counter is synthesised.

Structure
REQ-034 Package uart_baud_pkg SHALL hold:
- BAUD_W=13 and FRAC_W=3;
- the FSM state enum;
- the DRAIN_TIMEOUT counter width.
REQ-035 The block SHALL contain one sub-module, uart_drain_qual.
- It implements the 2-cycle idle qualifier and the optional timeout counter.
- It outputs drain_ok and drain_timeout.

Verification
REQ-036 Scenario: reset release, then cfg 13'd325/3'd4 with tx/rx idle.
- Required: pause rises; 2 idle cycles; LOAD with gen_clear=1; baud_val=325 and baud_val_fraction=4.
- Required: cfg_done pulses the cycle after the first baud_clock.
REQ-037 Scenario: tx_busy held 1 for 50 cycles after a handshake.
- Required: LOAD does not occur before 2 cycles after tx_busy falls.
- Required: baud_val is unchanged until then.
REQ-038 Scenario: with the macro defined and DRAIN_TIMEOUT=16, rx_busy held 1.
- Required: cfg_err pulses on the 16th DRAIN cycle; baud_val keeps its old value; cfg_ready returns to 1.
REQ-039 Scenario: a second cfg_valid offered during SYNC.
- Required: it is not accepted.
- Required: it is accepted on the first IDLE cycle after cfg_done.
REQ-040 Scenario: reset_n pulsed low during DRAIN.
- Required: outputs return to reset values; no cfg_done pulse.
REQ-041 Scenario: cfg_baud_val=0.
- Required: cfg_done follows one cycle after the first baud_clock pulse; baud_val=0.
